// File: rtl/debug_pkg.sv
// Shared definitions for the debug input peripheral: register map and default
// debounce length used by the top level and the testbench.
package debug_pkg;

  typedef logic [7:0] dbg_addr_t;

  localparam dbg_addr_t DBG_IN_ADDR   = 8'h00;
  localparam dbg_addr_t DBG_RISE_ADDR = 8'h04;
  localparam dbg_addr_t DBG_FALL_ADDR = 8'h08;
  localparam dbg_addr_t DBG_IE_ADDR   = 8'h0C;
  localparam dbg_addr_t DBG_RAW_ADDR  = 8'h10;

  localparam int DBG_DEBOUNCE_DEFAULT = 16;
  localparam int DBG_CNT_W_DEFAULT    = 16;

endpackage

// File: rtl/debug_input_module_if.sv
// Peripheral bus seen by the debug input block: 8-bit address, 32-bit data,
// single-cycle write and read strobes, combinational read data.
interface debug_input_module_if;
  import debug_pkg::*;

  dbg_addr_t   address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        we;
  logic        re;

  modport master (
    output address,
    output write_data,
    output we,
    output re,
    input  read_data
  );

  modport slave (
    input  address,
    input  write_data,
    input  we,
    input  re,
    output read_data
  );

endinterface

// File: rtl/debug_in_debounce.sv
// One debug pin: two-flop synchroniser followed by a counter-based debouncer
// that emits single-cycle rise/fall pulses when a new level is accepted.
module debug_in_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync_out,
  output logic stable_out,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // The pulse is asserted in the cycle before stable flips so the flag
  // register and stable update on the same edge.
  assign accept = (sync2 != stable) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (sync2 == stable) begin
      cnt <= '0;
    end else if (accept) begin
      stable <= sync2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign sync_out   = sync2;
  assign stable_out = stable;
  assign rise       = accept & sync2;
  assign fall       = accept & ~sync2;

endmodule

// File: rtl/debug_input_module.sv
// Memory-mapped debug input peripheral: eight debounced pins, sticky W1C edge
// flags, interrupt enable mask and a level interrupt.
module debug_input_module
  import debug_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DBG_DEBOUNCE_DEFAULT,
  parameter int CNT_W           = DBG_CNT_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  debug_input_module_if.slave  bus,
  input  logic [7:0]           debug_in,
  output logic                 irq
);

  logic [7:0] sync_bits;
  logic [7:0] stable_bits;
  logic [7:0] rise_pulse;
  logic [7:0] fall_pulse;
  logic [7:0] rise_flags;
  logic [7:0] fall_flags;
  logic [7:0] ie;
  logic [7:0] rise_clr;
  logic [7:0] fall_clr;
  logic       wr_ie;
  logic       unused_bus;

  for (genvar i = 0; i < 8; i++) begin : g_pin
    debug_in_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debounce (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (debug_in[i]),
      .sync_out   (sync_bits[i]),
      .stable_out (stable_bits[i]),
      .rise       (rise_pulse[i]),
      .fall       (fall_pulse[i])
    );
  end

  assign rise_clr = (bus.we && bus.address == DBG_RISE_ADDR) ? bus.write_data[7:0] : 8'h00;
  assign fall_clr = (bus.we && bus.address == DBG_FALL_ADDR) ? bus.write_data[7:0] : 8'h00;
  assign wr_ie    = bus.we && (bus.address == DBG_IE_ADDR);

  // Clear is applied before set so an edge arriving with a W1C write survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_flags <= 8'h00;
      fall_flags <= 8'h00;
      ie         <= 8'h00;
    end else begin
      rise_flags <= (rise_flags & ~rise_clr) | rise_pulse;
      fall_flags <= (fall_flags & ~fall_clr) | fall_pulse;
      if (wr_ie) begin
        ie <= bus.write_data[7:0];
      end
    end
  end

  always_comb begin
    bus.read_data = 32'h0;
    case (bus.address)
      DBG_IN_ADDR:   bus.read_data = {24'h0, stable_bits};
      DBG_RISE_ADDR: bus.read_data = {24'h0, rise_flags};
      DBG_FALL_ADDR: bus.read_data = {24'h0, fall_flags};
      DBG_IE_ADDR:   bus.read_data = {24'h0, ie};
      DBG_RAW_ADDR:  bus.read_data = {24'h0, sync_bits};
      default:       bus.read_data = 32'h0;
    endcase
  end

  assign irq = |((rise_flags | fall_flags) & ie);

  // Reads have no side effects and the upper write bits are never stored.
  assign unused_bus = &{1'b0, bus.re, bus.write_data[31:8]};

endmodule

// File: tb/tb_debug_input_module.sv
// Randomised scoreboard bench for debug_input_module, checked against a
// sample-history reference model of the debounced pins and flag registers.
module tb_debug_input_module;
  import debug_pkg::*;

  localparam int N    = 4;
  localparam int HIST = N + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] debug_in = 8'h00;
  logic       irq;

  int num_checks = 0;
  int num_fails  = 0;

  debug_input_module_if bus ();

  debug_input_module #(
    .DEBOUNCE_CYCLES (N),
    .CNT_W           (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .debug_in (debug_in),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  // Reference model: a pin level is accepted once the synchronised samples
  // seen on the last N edges all disagree with the current accepted level.
  logic [7:0] din_hist[$];
  logic [7:0] m_stable, m_rise, m_fall, m_ie;

  task automatic reset_model();
    din_hist.delete();
    repeat (HIST) din_hist.push_back(8'h00);
    m_stable = 8'h00;
    m_rise   = 8'h00;
    m_fall   = 8'h00;
    m_ie     = 8'h00;
  endtask

  always @(posedge clk) begin
    logic [7:0] fire, clr_r, clr_f;
    if (!rst_n) begin
      reset_model();
    end else begin
      din_hist.push_front(debug_in);
      while (din_hist.size() > HIST) void'(din_hist.pop_back());
      fire = 8'hFF;
      for (int w = 2; w <= N + 1; w++) fire &= din_hist[w] ^ m_stable;
      clr_r = (bus.we && bus.address == DBG_RISE_ADDR) ? bus.write_data[7:0] : 8'h00;
      clr_f = (bus.we && bus.address == DBG_FALL_ADDR) ? bus.write_data[7:0] : 8'h00;
      m_rise = (m_rise & ~clr_r) | (fire & ~m_stable);
      m_fall = (m_fall & ~clr_f) | (fire & m_stable);
      if (bus.we && bus.address == DBG_IE_ADDR) m_ie = bus.write_data[7:0];
      m_stable = m_stable ^ fire;
    end
  end

  function automatic logic [31:0] model_read(input logic [7:0] a);
    case (a)
      DBG_IN_ADDR:   return {24'h0, m_stable};
      DBG_RISE_ADDR: return {24'h0, m_rise};
      DBG_FALL_ADDR: return {24'h0, m_fall};
      DBG_IE_ADDR:   return {24'h0, m_ie};
      DBG_RAW_ADDR:  return {24'h0, din_hist[1]};
      default:       return 32'h0;
    endcase
  endfunction

  function automatic logic model_irq();
    return |((m_rise | m_fall) & m_ie);
  endfunction

  typedef struct {
    string       name;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: every read strobe pops one expectation and checks data and irq.
  always @(negedge clk) begin
    if (bus.re) begin
      if (exp_q.size() == 0) begin
        checkOutput("read_without_expectation", 32'd1, 32'd0);
      end else begin
        cur = exp_q.pop_front();
        checkOutput({cur.name, "_data"}, bus.read_data, cur.data);
        checkOutput({cur.name, "_irq"}, {31'h0, irq}, {31'h0, cur.irq});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic bus_read(input string name, input logic [7:0] a);
    bus.address = a;
    bus.re      = 1'b1;
    bus.we      = 1'b0;
    exp_q.push_back('{name, a, model_read(a), model_irq()});
    tick();
    bus.re = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.write_data = d;
    bus.we         = 1'b1;
    bus.re         = 1'b0;
    tick();
    bus.we = 1'b0;
  endtask

  task automatic applyStimulus(input int iterations);
    logic [7:0] addrs[7];
    addrs = '{DBG_IN_ADDR, DBG_RISE_ADDR, DBG_FALL_ADDR, DBG_IE_ADDR, DBG_RAW_ADDR, 8'h14, 8'hFC};
    for (int it = 0; it < iterations; it++) begin
      if ($urandom_range(7) == 0) debug_in = debug_in ^ 8'($urandom);
      case ($urandom_range(3))
        0, 1: bus_read("rand_read", addrs[$urandom_range(6)]);
        2:    bus_write(addrs[$urandom_range(1, 6)], $urandom);
        default: idle(1);
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, got %0t, expected under 200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.address    = 8'h00;
    bus.write_data = 32'h0;
    bus.we         = 1'b0;
    bus.re         = 1'b0;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] reset state");
    bus_read("rst_in", DBG_IN_ADDR);
    bus_read("rst_rise", DBG_RISE_ADDR);
    bus_read("rst_fall", DBG_FALL_ADDR);
    bus_read("rst_ie", DBG_IE_ADDR);
    bus_read("rst_raw", DBG_RAW_ADDR);

    $display("[TB] debounce latency");
    bus_write(DBG_IE_ADDR, 32'h1);
    debug_in[0] = 1'b1;
    repeat (6) bus_read("lat_in", DBG_IN_ADDR);
    bus_read("lat_rise", DBG_RISE_ADDR);

    $display("[TB] glitch rejection");
    bus_write(DBG_RISE_ADDR, 32'hFF);
    debug_in[3] = 1'b1;
    repeat (3) bus_read("glitch_raw", DBG_RAW_ADDR);
    debug_in[3] = 1'b0;
    bus_read("glitch_raw_tail", DBG_RAW_ADDR);
    idle(4);
    bus_read("glitch_in", DBG_IN_ADDR);
    bus_read("glitch_rise", DBG_RISE_ADDR);
    bus_read("glitch_fall", DBG_FALL_ADDR);

    $display("[TB] write-1-to-clear");
    debug_in = 8'h00;
    idle(8);
    bus_write(DBG_RISE_ADDR, 32'hFF);
    bus_write(DBG_FALL_ADDR, 32'hFF);
    debug_in = 8'h05;
    idle(8);
    bus_read("w1c_rise_before", DBG_RISE_ADDR);
    bus_write(DBG_RISE_ADDR, 32'h4);
    bus_read("w1c_rise_after", DBG_RISE_ADDR);
    bus_write(DBG_FALL_ADDR, 32'hFFFF_FFFF);
    bus_read("w1c_fall_zero", DBG_FALL_ADDR);

    $display("[TB] set wins over clear");
    debug_in[2] = 1'b0;
    idle(8);
    debug_in[2] = 1'b1;
    idle(N + 1);
    bus_write(DBG_RISE_ADDR, 32'h4);
    bus_read("collide_rise", DBG_RISE_ADDR);

    $display("[TB] mask and unmapped");
    bus_write(DBG_IE_ADDR, 32'h0);
    bus_write(DBG_RISE_ADDR, 32'hFF);
    bus_write(DBG_FALL_ADDR, 32'hFF);
    debug_in[7] = 1'b1;
    idle(8);
    debug_in[7] = 1'b0;
    idle(8);
    bus_write(DBG_RISE_ADDR, 32'hFF);
    bus_read("mask_fall", DBG_FALL_ADDR);
    bus_write(DBG_IE_ADDR, 32'hFFFF_FF80);
    bus_read("mask_ie", DBG_IE_ADDR);
    bus_read("unmapped_read", 8'h14);
    bus_write(8'h14, 32'hFFFF_FFFF);
    bus_read("unmapped_in", DBG_IN_ADDR);
    bus_read("unmapped_rise", DBG_RISE_ADDR);
    bus_read("unmapped_fall", DBG_FALL_ADDR);
    bus_read("unmapped_ie", DBG_IE_ADDR);

    $display("[TB] reset during debounce");
    debug_in = 8'hFF;
    idle(3);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    bus_read("midrst_in", DBG_IN_ADDR);
    bus_read("midrst_rise", DBG_RISE_ADDR);
    repeat (N + 2) bus_read("midrst_settle", DBG_IN_ADDR);
    bus_read("midrst_rise_late", DBG_RISE_ADDR);

    $display("[TB] randomised traffic");
    applyStimulus(400);

    idle(2);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
